// File: rtl/ov7670_sccb_responder_pkg.sv
// Shared definitions for the OV7670 SCCB responder: FSM encoding, register map
// constants and the power-on register defaults.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ID        = 4'd1,
    ST_ID_ACK    = 4'd2,
    ST_SUB       = 4'd3,
    ST_SUB_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RNACK     = 4'd8,
    ST_IGNORE    = 4'd9
  } state_t;

  localparam logic [7:0] REG_COM7    = 8'h12;
  localparam logic [7:0] REG_PID     = 8'h0A;
  localparam logic [7:0] REG_VER     = 8'h0B;
  localparam logic [7:0] PID_DEFAULT = 8'h76;
  localparam logic [7:0] VER_DEFAULT = 8'h73;
  localparam logic [7:0] ID_WRITE    = 8'h42;
  localparam logic [7:0] ID_READ     = 8'h43;

  function automatic logic [7:0] reg_default(input logic [7:0] addr);
    case (addr)
      REG_PID: return PID_DEFAULT;
      REG_VER: return VER_DEFAULT;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ov7670_sccb_responder_line_sync.sv
// Synchronises the asynchronous SIOC/SIOD pads and turns them into registered
// rise/fall/START/STOP pulses plus the SIOD level aligned with those pulses.
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sioc_i,
  input  logic siod_i,
  output logic rise,
  output logic fall,
  output logic start,
  output logic stop,
  output logic bit_val
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl_now;
  logic                   sda_now;

  assign scl_now = scl_sync[SYNC_STAGES-1];
  assign sda_now = sda_sync[SYNC_STAGES-1];

  // Both lines share one pipeline depth so START/STOP never see skewed edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= {SYNC_STAGES{1'b1}};
      sda_sync <= {SYNC_STAGES{1'b1}};
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
      rise     <= 1'b0;
      fall     <= 1'b0;
      start    <= 1'b0;
      stop     <= 1'b0;
      bit_val  <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], sioc_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], siod_i};
      scl_prev <= scl_now;
      sda_prev <= sda_now;
      rise     <= scl_now & ~scl_prev;
      fall     <= ~scl_now & scl_prev;
      start    <= scl_now & scl_prev & sda_prev & ~sda_now;
      stop     <= scl_now & scl_prev & ~sda_prev & sda_now;
      bit_val  <= sda_now;
    end
  end

endmodule

// File: rtl/ov7670_sccb_responder.sv
// OV7670-style SCCB register responder: decodes 3-phase writes and 2-phase
// write + 2-phase read transactions against a 256x8 register file.
module ov7670_sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h21,
  parameter int         SYNC_STAGES = 2,
  parameter bit         ACK_DRIVE   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sioc_i,
  input  logic       siod_i,
  output logic       siod_oe,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  logic       rise, fall, start, stop, bit_val;
  state_t     state, state_nxt;
  logic [3:0] bit_cnt, cnt_nxt;
  logic [7:0] shift, shift_nxt;
  logic [7:0] sub_addr, sub_nxt;
  logic       oe_nxt, busy_nxt, commit;
  logic [7:0] rd_byte;
  logic [7:0] regs [256];

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sioc_i (sioc_i),
    .siod_i (siod_i),
    .rise   (rise),
    .fall   (fall),
    .start  (start),
    .stop   (stop),
    .bit_val(bit_val)
  );

  assign rd_byte = regs[sub_addr];

  // Next-state logic: bits shift in on rise, all slot/state changes occur on fall.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    shift_nxt = shift;
    sub_nxt   = sub_addr;
    oe_nxt    = siod_oe;
    busy_nxt  = busy;
    commit    = 1'b0;
    if (stop) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = 4'd0;
      oe_nxt    = 1'b0;
      busy_nxt  = 1'b0;
    end else if (start) begin
      state_nxt = ST_ID;
      cnt_nxt   = 4'd0;
      oe_nxt    = 1'b0;
      busy_nxt  = 1'b1;
    end else if (rise) begin
      if ((state == ST_ID || state == ST_SUB || state == ST_WDATA) && bit_cnt < 4'd8) begin
        shift_nxt = {shift[6:0], bit_val};
        cnt_nxt   = bit_cnt + 4'd1;
      end else begin
        cnt_nxt = bit_cnt;
      end
    end else if (fall) begin
      case (state)
        ST_ID: begin
          if (bit_cnt == 4'd8) begin
            if (shift[7:1] == DEV_ADDR) begin
              state_nxt = ST_ID_ACK;
              oe_nxt    = ACK_DRIVE;
            end else begin
              state_nxt = ST_IGNORE;
              oe_nxt    = 1'b0;
            end
          end else begin
            state_nxt = ST_ID;
          end
        end
        ST_ID_ACK: begin
          if (shift[0]) begin
            state_nxt = ST_RDATA;
            shift_nxt = rd_byte;
            oe_nxt    = ~rd_byte[7];
            cnt_nxt   = 4'd1;
          end else begin
            state_nxt = ST_SUB;
            oe_nxt    = 1'b0;
            cnt_nxt   = 4'd0;
          end
        end
        ST_SUB: begin
          if (bit_cnt == 4'd8) begin
            state_nxt = ST_SUB_ACK;
            oe_nxt    = ACK_DRIVE;
          end else begin
            state_nxt = ST_SUB;
          end
        end
        ST_SUB_ACK: begin
          state_nxt = ST_WDATA;
          sub_nxt   = shift;
          oe_nxt    = 1'b0;
          cnt_nxt   = 4'd0;
        end
        ST_WDATA: begin
          if (bit_cnt == 4'd8) begin
            state_nxt = ST_WDATA_ACK;
            oe_nxt    = ACK_DRIVE;
          end else begin
            state_nxt = ST_WDATA;
          end
        end
        ST_WDATA_ACK: begin
          // No auto-increment: anything after the first data byte is ignored.
          commit    = 1'b1;
          state_nxt = ST_IGNORE;
          oe_nxt    = 1'b0;
          cnt_nxt   = 4'd0;
        end
        ST_RDATA: begin
          if (bit_cnt == 4'd8) begin
            state_nxt = ST_RNACK;
            oe_nxt    = 1'b0;
            cnt_nxt   = 4'd0;
          end else begin
            oe_nxt    = ~shift[6];
            shift_nxt = {shift[6:0], 1'b0};
            cnt_nxt   = bit_cnt + 4'd1;
          end
        end
        ST_RNACK: begin
          state_nxt = ST_IGNORE;
          oe_nxt    = 1'b0;
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end else begin
      state_nxt = state;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= 4'd0;
      shift     <= 8'h00;
      sub_addr  <= 8'h00;
      siod_oe   <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= cnt_nxt;
      shift     <= shift_nxt;
      sub_addr  <= sub_nxt;
      siod_oe   <= oe_nxt;
      busy      <= busy_nxt;
      wr_strobe <= commit;
      if (commit) begin
        wr_addr <= sub_addr;
        wr_data <= shift;
      end else begin
        wr_addr <= wr_addr;
        wr_data <= wr_data;
      end
    end
  end

  // Register file; PID/VER are read-only and COM7[7] restores every default.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) regs[i] <= reg_default(8'(i));
    end else if (commit) begin
      if (sub_addr == REG_COM7 && shift[7]) begin
        for (int i = 0; i < 256; i++) regs[i] <= reg_default(8'(i));
      end else if (sub_addr != REG_PID && sub_addr != REG_VER) begin
        regs[sub_addr] <= shift;
      end else begin
        regs[sub_addr] <= regs[sub_addr];
      end
    end
  end

endmodule

// File: tb/tb_ov7670_sccb_responder.sv
// Directed bench: an open-drain SCCB master model drives the responder and
// checks ACK slots, read data, write strobes and abort/reset behaviour.
module tb_ov7670_sccb_responder;
  import sccb_pkg::*;

  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sioc = 1'b1;
  logic       siod_drv = 1'b1;
  logic       siod_line;
  logic       siod_oe, wr_strobe, busy;
  logic [7:0] wr_addr, wr_data;
  int         tests = 0, fails = 0, strobe_cnt = 0, oe_cnt = 0;

  assign siod_line = siod_drv & ~siod_oe;

  always #5 clk = ~clk;

  ov7670_sccb_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sioc_i   (sioc),
    .siod_i   (siod_line),
    .siod_oe  (siod_oe),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  always @(posedge clk) begin
    if (wr_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
    if (siod_oe === 1'b1) oe_cnt <= oe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic q_wait();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic tx_start();
    siod_drv = 1'b1; q_wait();
    sioc = 1'b1;     q_wait();
    siod_drv = 1'b0; q_wait();
    sioc = 1'b0;     q_wait();
  endtask

  task automatic tx_stop();
    siod_drv = 1'b0; q_wait();
    sioc = 1'b1;     q_wait();
    siod_drv = 1'b1; q_wait();
  endtask

  task automatic send_bit(input logic b, output logic line);
    siod_drv = b; q_wait();
    sioc = 1'b1;  q_wait();
    line = siod_line;
    q_wait();
    sioc = 1'b0;  q_wait();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic l;
    for (int i = 7; i >= 0; i--) send_bit(b[i], l);
    send_bit(1'b1, l);
    ack = ~l;
  endtask

  task automatic read_byte(output logic [7:0] d, output logic released);
    logic l;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, l);
      d[i] = l;
    end
    send_bit(1'b1, l);
    released = l;
  endtask

  task automatic wr_reg(input logic [7:0] addr, input logic [7:0] data);
    logic a;
    tx_start();
    chk("wr_busy", busy, 1);
    send_byte(8'h42, a); chk("wr_ack_id", a, 1);
    send_byte(addr, a);  chk("wr_ack_sub", a, 1);
    send_byte(data, a);  chk("wr_ack_data", a, 1);
    tx_stop();
  endtask

  task automatic read_reg(input logic [7:0] addr, output logic [7:0] d);
    logic a, rel;
    tx_start();
    send_byte(8'h42, a); chk("rd_ack_id_w", a, 1);
    send_byte(addr, a);  chk("rd_ack_sub", a, 1);
    tx_stop();
    tx_start();
    send_byte(8'h43, a); chk("rd_ack_id_r", a, 1);
    read_byte(d, rel);   chk("rd_nack_released", rel, 1);
    tx_stop();
  endtask

  initial begin
    logic [7:0] d;
    logic       a, l;
    int         s0, o0;

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    chk("rst_outputs", {siod_oe, wr_strobe, busy, wr_addr, wr_data}, 0);
    rst_n = 1'b1;
    q_wait();
    chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
    chk("rst_busy", busy, 0);

    // 3-phase write to COM7 (no reset bit) and read-back
    s0 = strobe_cnt;
    wr_reg(8'h12, 8'h04);
    chk("t1_strobes", strobe_cnt - s0, 1);
    chk("t1_wr_addr", wr_addr, 8'h12);
    chk("t1_wr_data", wr_data, 8'h04);
    chk("t1_busy_idle", busy, 0);
    read_reg(8'h12, d);
    chk("t1_read", d, 8'h04);

    // Read-only PID/VER
    read_reg(8'h0A, d);
    chk("t2_pid", d, 8'h76);
    s0 = strobe_cnt;
    wr_reg(8'h0A, 8'h55);
    chk("t2_ro_strobe", strobe_cnt - s0, 1);
    chk("t2_ro_wr_data", wr_data, 8'h55);
    read_reg(8'h0A, d);
    chk("t2_pid_kept", d, 8'h76);
    read_reg(8'h0B, d);
    chk("t2_ver", d, 8'h73);

    // Foreign device ID is ignored
    s0 = strobe_cnt;
    o0 = oe_cnt;
    tx_start();
    send_byte(8'h60, a); chk("t3_ack_id", a, 0);
    send_byte(8'h12, a); chk("t3_ack_sub", a, 0);
    send_byte(8'hFF, a); chk("t3_ack_data", a, 0);
    chk("t3_busy", busy, 1);
    tx_stop();
    chk("t3_oe_quiet", oe_cnt - o0, 0);
    chk("t3_no_strobe", strobe_cnt - s0, 0);
    chk("t3_busy_after", busy, 0);

    // STOP in the middle of the data byte aborts the write
    s0 = strobe_cnt;
    tx_start();
    send_byte(8'h42, a); chk("t4_ack_id", a, 1);
    send_byte(8'h3A, a); chk("t4_ack_sub", a, 1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, l);
    tx_stop();
    chk("t4_no_strobe", strobe_cnt - s0, 0);
    chk("t4_state", 32'(dut.state), 32'(ST_IDLE));
    read_reg(8'h3A, d);
    chk("t4_read", d, 8'h00);

    // COM7 soft reset restores defaults
    wr_reg(8'h11, 8'h80);
    read_reg(8'h11, d);
    chk("t5_pre", d, 8'h80);
    wr_reg(8'h12, 8'h80);
    read_reg(8'h11, d);
    chk("t5_r11", d, 8'h00);
    read_reg(8'h12, d);
    chk("t5_r12", d, 8'h00);
    read_reg(8'h0A, d);
    chk("t5_pid", d, 8'h76);

    // Repeated START after the sub-address
    tx_start();
    send_byte(8'h42, a); chk("t6_ack_id", a, 1);
    send_byte(8'h20, a); chk("t6_ack_sub", a, 1);
    tx_start();
    chk("t6_state_id", 32'(dut.state), 32'(ST_ID));
    chk("t6_oe", siod_oe, 0);
    send_byte(8'h42, a); chk("t6_ack_id2", a, 1);
    send_byte(8'h20, a); chk("t6_ack_sub2", a, 1);
    send_byte(8'h5A, a); chk("t6_ack_data2", a, 1);
    tx_stop();
    read_reg(8'h20, d);
    chk("t6_read", d, 8'h5A);

    // rst_n pulsed mid-byte: stays idle until a fresh START
    tx_start();
    send_byte(8'h42, a); chk("t7_ack_id", a, 1);
    send_bit(1'b1, l);
    send_bit(1'b0, l);
    send_bit(1'b1, l);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q_wait();
    chk("t7_state_idle", 32'(dut.state), 32'(ST_IDLE));
    chk("t7_oe", siod_oe, 0);
    chk("t7_busy", busy, 0);
    send_byte(8'h42, a); chk("t7_no_resync_ack", a, 0);
    chk("t7_still_idle", 32'(dut.state), 32'(ST_IDLE));
    tx_stop();
    read_reg(8'h20, d);
    chk("t7_regs_reset", d, 8'h00);
    wr_reg(8'h21, 8'h33);
    read_reg(8'h21, d);
    chk("t7_clean_txn", d, 8'h33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
